// File: rtl/hdmi_i2c_cfg_seq.sv
// Write-only I2C master that plays a {reg,data} table into the HDMI transmitter, replaying on hot-plug events.
// Latency: OE outputs change 1 cycle after each quarter-bit tick; one ACKed entry takes 120 quarter ticks.
// Backpressure: none on the table side (combinational ROM); slave NACKs trigger bounded per-entry retries.
module hdmi_i2c_cfg_seq #(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          I2C_HZ    = 100_000,
    parameter logic [7:0]  DEV_ADDR  = 8'h72,
    parameter int          LUT_LEN   = 31,
    parameter int          MAX_RETRY = 3,
    parameter int          INIT_QT   = 16
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    output logic [5:0]  oLUT_IDX,
    input  logic [15:0] iLUT_DATA,
    input  logic        iHPD_INT,
    input  logic        iSDA,
    output logic        oSCL_OE,
    output logic        oSDA_OE,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERR
);
    // Quarter-bit divider; QDIV must be at least 2 for the 4-phase bit timing to hold.
    localparam int QDIV = CLK_HZ / (4 * I2C_HZ);
    localparam int DW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {
        S_INIT, S_START, S_BITS, S_ACK, S_STOP, S_GAP, S_DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic          qtick;
    logic [1:0]    q;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [15:0]   init_cnt;
    logic [7:0]    retry_cnt;
    logic [23:0]   shreg;
    logic          nack;
    logic          pending;
    logic          hpd_s1, hpd_s2, hpd_s3, hpd_evt;

    assign qtick = (div == DW'(QDIV - 1));

    // Free-running quarter-bit divider, independent of FSM state.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) div <= '0;
        else         div <= qtick ? '0 : div + 1'b1;
    end

    // Two-flop synchronizer plus registered rising-edge detect for the hot-plug line.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            hpd_s1  <= 1'b0;
            hpd_s2  <= 1'b0;
            hpd_s3  <= 1'b0;
            hpd_evt <= 1'b0;
        end else begin
            hpd_s1  <= iHPD_INT;
            hpd_s2  <= hpd_s1;
            hpd_s3  <= hpd_s2;
            hpd_evt <= hpd_s2 & ~hpd_s3;
        end
    end

    // Sequencer FSM: each 4-phase state performs phase q's action on a qtick, then moves q on.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state     <= S_INIT;
            q         <= 2'd0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            init_cnt  <= 16'd0;
            retry_cnt <= 8'd0;
            shreg     <= 24'd0;
            nack      <= 1'b0;
            pending   <= 1'b0;
            oLUT_IDX  <= 6'd0;
            oSCL_OE   <= 1'b0;
            oSDA_OE   <= 1'b0;
            oBUSY     <= 1'b0;
            oDONE     <= 1'b0;
            oERR      <= 1'b0;
        end else begin
            // Events during INIT are redundant (playback starts at 0 anyway); DONE handles its own.
            if (hpd_evt && state != S_INIT && state != S_DONE) pending <= 1'b1;

            case (state)
                S_INIT: begin
                    oBUSY <= 1'b1;
                    if (qtick) begin
                        if (init_cnt == 16'(INIT_QT - 1)) begin
                            state <= S_START;
                            q     <= 2'd0;
                        end else begin
                            init_cnt <= init_cnt + 16'd1;
                        end
                    end
                end
                S_START: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: begin
                            oSCL_OE  <= 1'b0;
                            oSDA_OE  <= 1'b0;
                            // Latched here rather than on the transition so the index update has settled.
                            shreg    <= {DEV_ADDR, iLUT_DATA};
                            byte_cnt <= 2'd0;
                            bit_cnt  <= 3'd0;
                            nack     <= 1'b0;
                        end
                        2'd1, 2'd2: oSDA_OE <= 1'b1;
                        default: begin
                            oSCL_OE <= 1'b1;
                            state   <= S_BITS;
                        end
                    endcase
                end
                S_BITS: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: begin
                            oSCL_OE <= 1'b1;
                            oSDA_OE <= ~shreg[23];
                        end
                        2'd1: oSCL_OE <= 1'b0;
                        2'd2: ;
                        default: begin
                            oSCL_OE <= 1'b1;
                            shreg   <= {shreg[22:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= S_ACK;
                        end
                    endcase
                end
                S_ACK: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: begin
                            oSCL_OE <= 1'b1;
                            oSDA_OE <= 1'b0;
                        end
                        2'd1: oSCL_OE <= 1'b0;
                        2'd2: if (iSDA) nack <= 1'b1;
                        default: begin
                            oSCL_OE <= 1'b1;
                            if (nack || byte_cnt == 2'd2) begin
                                state <= S_STOP;
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                                state    <= S_BITS;
                            end
                        end
                    endcase
                end
                S_STOP: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: begin
                            oSCL_OE <= 1'b1;
                            oSDA_OE <= 1'b1;
                        end
                        2'd1: oSCL_OE <= 1'b0;
                        2'd2: oSDA_OE <= 1'b0;
                        default: state <= S_GAP;
                    endcase
                end
                S_GAP: if (qtick) begin
                    q <= q + 2'd1;
                    if (q == 2'd3) begin
                        if (pending || hpd_evt) begin
                            pending   <= 1'b0;
                            oERR      <= 1'b0;
                            retry_cnt <= 8'd0;
                            oLUT_IDX  <= 6'd0;
                            state     <= S_START;
                        end else if (nack && retry_cnt < 8'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 8'd1;
                            state     <= S_START;
                        end else begin
                            if (nack) oERR <= 1'b1;
                            retry_cnt <= 8'd0;
                            if (oLUT_IDX == 6'(LUT_LEN - 1)) begin
                                state <= S_DONE;
                                oBUSY <= 1'b0;
                                oDONE <= 1'b1;
                            end else begin
                                oLUT_IDX <= oLUT_IDX + 6'd1;
                                state    <= S_START;
                            end
                        end
                    end
                end
                S_DONE: begin
                    oSCL_OE <= 1'b0;
                    oSDA_OE <= 1'b0;
                    if (hpd_evt) begin
                        oDONE     <= 1'b0;
                        oERR      <= 1'b0;
                        oBUSY     <= 1'b1;
                        oLUT_IDX  <= 6'd0;
                        retry_cnt <= 8'd0;
                        q         <= 2'd0;
                        state     <= S_START;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_hdmi_i2c_cfg_seq.sv
// Bench for hdmi_i2c_cfg_seq: bus-level slave model decodes transactions into a queue checked against expectations.
// Latency: observes outputs on the falling clock edge.
// Backpressure: slave ACK/NACK behaviour selected per test step.
module tb_hdmi_i2c_cfg_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  lut_idx;
    logic [15:0] lut_data;
    logic        hpd = 1'b0;
    logic        isda;
    logic        scl_oe, sda_oe, busy, done, err;

    always #5 clk = ~clk;

    assign lut_data = (lut_idx == 6'd0) ? 16'h4110 : (lut_idx == 6'd1) ? 16'h9803 : 16'h0000;

    hdmi_i2c_cfg_seq #(
        .CLK_HZ(800), .I2C_HZ(100), .DEV_ADDR(8'h72),
        .LUT_LEN(2), .MAX_RETRY(3), .INIT_QT(16)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .oLUT_IDX(lut_idx), .iLUT_DATA(lut_data),
        .iHPD_INT(hpd), .iSDA(isda), .oSCL_OE(scl_oe), .oSDA_OE(sda_oe),
        .oBUSY(busy), .oDONE(done), .oERR(err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Slave model state.
    logic        slave_pull = 1'b0;
    logic        scl_p = 1'b1, sda_p = 1'b1;
    bit          in_xfer = 1'b0;
    int          bitn = 0;
    int          nbytes = 0;
    logic [7:0]  shbyte = 8'h00;
    logic [23:0] cur = 24'h0;
    bit          nacked = 1'b0;
    int          nack_mode = 0;   // 0 ack all, 1 NACK data byte of reg 41 always, 2 NACK it once
    bit          first_pend = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    assign isda = ~(sda_oe | slave_pull);

    // Bus monitor / slave: decodes START, bits, ACK slot and STOP from the open-drain levels.
    always @(negedge clk) begin
        logic scl, sda, do_nack;
        scl = ~scl_oe;
        sda = ~(sda_oe | slave_pull);
        if (!rst_n) begin
            in_xfer    = 1'b0;
            slave_pull = 1'b0;
            bitn       = 0;
        end else if (scl && scl_p && sda_p && !sda) begin
            in_xfer = 1'b1; bitn = 0; nbytes = 0; cur = 24'h0; nacked = 1'b0;
        end else if (scl && scl_p && !sda_p && sda) begin
            if (in_xfer) got_q.push_back({3'b0, nacked, 4'(nbytes), cur});
            in_xfer = 1'b0;
        end else if (in_xfer && scl && !scl_p) begin
            if (bitn < 8) shbyte = {shbyte[6:0], sda};
            else if (bitn == 8 && sda) nacked = 1'b1;
            bitn++;
        end else if (in_xfer && !scl && scl_p) begin
            if (bitn == 8) begin
                do_nack = (nbytes == 2) && (cur[7:0] == 8'h41) &&
                          ((nack_mode == 1) || (nack_mode == 2 && first_pend));
                if (do_nack && nack_mode == 2) first_pend = 1'b0;
                slave_pull = ~do_nack;
            end else if (bitn == 9) begin
                slave_pull = 1'b0;
                bitn = 0;
                cur = {cur[15:0], shbyte};
                nbytes++;
            end
        end
        scl_p = scl;
        sda_p = ~(sda_oe | slave_pull);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [15:0] lut, input bit nk);
        exp_q.push_back({3'b0, nk, 4'd3, 8'h72, lut});
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic compare_sb(input string tag);
        logic [31:0] e, g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                check({tag, "_missing"}, 32'(got_q.size()), 32'(exp_q.size() + 1));
                break;
            end
            g = got_q.pop_front();
            check(tag, g, e);
        end
        exp_q.delete();
        check({tag, "_extra"}, 32'(got_q.size()), 32'd0);
        got_q.delete();
    endtask

    // 3-cycle HPD pulse while in DONE; oDONE must drop within 4 cycles of the pulse start.
    task automatic hpd_from_done(input string tag);
        int fell_k;
        fell_k = 0;
        @(negedge clk);
        hpd = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) hpd = 1'b0;
            if (!done && fell_k == 0) fell_k = k;
        end
        check({tag, "_latency_ok"}, {31'b0, (fell_k >= 1 && fell_k <= 4)}, 32'd1);
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_err_clr"}, {31'b0, err}, 32'd0);
        check({tag, "_idx0"}, {26'b0, lut_idx}, 32'd0);
    endtask

    task automatic hpd_pulse();
        @(negedge clk);
        hpd = 1'b1;
        repeat (3) @(negedge clk);
        hpd = 1'b0;
    endtask

    initial begin
        int cyc, n;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scl", {31'b0, scl_oe}, 32'd0);
        check("rst_sda", {31'b0, sda_oe}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_idx", {26'b0, lut_idx}, 32'd0);

        // Plain playback, all ACKed; oDONE expected at 16*2 + 240*2 cycles.
        nack_mode = 0;
        push_exp(16'h4110, 1'b0);
        push_exp(16'h9803, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("init_busy", {31'b0, busy}, 32'd1);
        wait_done("play1_done", cyc);
        cyc = cyc + 1;
        check("play1_time_ok", {31'b0, (cyc >= 510 && cyc <= 514)}, 32'd1);
        check("play1_err", {31'b0, err}, 32'd0);
        check("play1_busy", {31'b0, busy}, 32'd0);
        check("play1_idx_hold", {26'b0, lut_idx}, 32'd1);
        compare_sb("play1_xfer");

        // Persistent NACK on entry 0 data: 4 attempts, then entry 1, oERR set.
        nack_mode = 1;
        repeat (4) push_exp(16'h4110, 1'b1);
        push_exp(16'h9803, 1'b0);
        hpd_from_done("hpd1");
        wait_done("nack_done", cyc);
        check("nack_err", {31'b0, err}, 32'd1);
        compare_sb("nack_xfer");

        // Replay from DONE clears oERR; all ACKed.
        nack_mode = 0;
        push_exp(16'h4110, 1'b0);
        push_exp(16'h9803, 1'b0);
        hpd_from_done("hpd2");
        wait_done("replay_done", cyc);
        check("replay_err", {31'b0, err}, 32'd0);
        compare_sb("replay_xfer");

        // Single NACK: one retry succeeds, oERR stays clear.
        nack_mode = 2;
        first_pend = 1'b1;
        push_exp(16'h4110, 1'b1);
        push_exp(16'h4110, 1'b0);
        push_exp(16'h9803, 1'b0);
        hpd_from_done("hpd3");
        wait_done("retry1_done", cyc);
        check("retry1_err", {31'b0, err}, 32'd0);
        compare_sb("retry1_xfer");

        // Two HPD pulses during entry 1: entry 1 finishes, then exactly one restart.
        nack_mode = 0;
        push_exp(16'h4110, 1'b0);
        push_exp(16'h9803, 1'b0);
        push_exp(16'h4110, 1'b0);
        push_exp(16'h9803, 1'b0);
        hpd_from_done("hpd4");
        n = 0;
        while (lut_idx != 6'd1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("pend_idx1", {26'b0, lut_idx}, 32'd1);
        repeat (30) @(negedge clk);
        hpd_pulse();
        repeat (10) @(negedge clk);
        hpd_pulse();
        wait_done("pend_done", cyc);
        repeat (1000) @(negedge clk);
        check("pend_still_done", {31'b0, done}, 32'd1);
        compare_sb("pend_xfer");

        // Reset mid-byte, then INIT timing restarts; first SDA-low of START at cycle 36.
        hpd_from_done("hpd5");
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_scl", {31'b0, scl_oe}, 32'd0);
        check("mrst_sda", {31'b0, sda_oe}, 32'd0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        n = 0;
        while (!sda_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mrst_start_cycle", 32'(n), 32'd36);
        check("mrst_start_scl", {31'b0, scl_oe}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hdmi_i2c_cfg_seq.md
# hdmi_i2c_cfg_seq

Write-only I2C master and register-table sequencer for the HDMI transmitter configuration path. After reset it plays an external register table into the transmitter: one 3-byte write per entry (device address, register, data). It re-plays the table whenever the transmitter raises its hot-plug/interrupt line. It sits between the 50 MHz board clock domain and the open-drain HDMI_I2C_SCL/SDA pads; the top level ties each pad to 1'bz unless its OE is high, in which case it drives 1'b0.

## Interface
- CLK_HZ, 50_000_000: iCLK frequency.
- I2C_HZ, 100_000: SCL rate. Quarter-bit divider QDIV = CLK_HZ/(4*I2C_HZ), and must be ≥ 2.
- DEV_ADDR, 8'h72: 8-bit write address sent as byte 0 (R/W bit = 0).
- LUT_LEN, 31: number of table entries. Range 1..64.
- MAX_RETRY, 3: extra attempts per entry after a NACK.
- INIT_QT, 16: power-up idle time, in quarter ticks, before the first START.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  reset, synchronous, active-low.
- oLUT_IDX  out  6  current table index.
- iLUT_DATA  in  16  {reg[15:8], data[7:0]} for oLUT_IDX. Combinational ROM, valid in the same cycle.
- iHPD_INT  in  1  asynchronous level from HDMI_TX_INT.
- iSDA  in  1  SDA pad value, used for ACK sampling.
- oSCL_OE  out  1  1 = pull SCL low.
- oSDA_OE  out  1  1 = pull SDA low.
- oBUSY  out  1  table playback in progress.
- oDONE  out  1  table fully played.
- oERR  out  1  at least one entry exhausted its retries during this playback.

## Operation
- Reset (iRST_N low at a rising edge): all outputs 0. Bus released. State INIT, divider 0, oLUT_IDX 0, retry count 0, pending flag 0.
- Divider counts 0..QDIV-1. The qtick pulse fires at QDIV-1. All bus activity advances only on qtick.
- iHPD_INT passes through a 2-FF synchronizer. A rising edge on the synchronized signal is an HPD event.
- States:
  - INIT: wait INIT_QT qticks → START. oBUSY=1 from the first cycle after reset.
  - START: 4 qticks. q0 SDA released, SCL released; q1 SDA low; q2 SDA low; q3 SCL low.
  - BITS: 3 bytes, MSB first: DEV_ADDR, iLUT_DATA[15:8], iLUT_DATA[7:0]. Data is latched at START entry.
    - Each bit takes 4 qticks: q0 SCL low and SDA set (OE = ~bit); q1 SCL released; q2 hold; q3 SCL low.
  - ACK: after each byte, SDA released for one bit slot; iSDA sampled at q2.
    - 0 → next byte, or STOP after byte 2.
    - 1 → NACK flag set, go to STOP.
  - STOP: 4 qticks. q0 SCL low, SDA low; q1 SCL released; q2 SDA released; q3 idle.
  - GAP: 4 idle qticks, then decide:
    - Pending HPD event → clear pending, oERR, retry count and index; restart at START.
    - NACK and retry count < MAX_RETRY → increment retry count, same index.
    - NACK and retries exhausted → oERR=1, advance.
    - Otherwise advance.
    - Advance: index++ and retry count cleared. If index reaches LUT_LEN → DONE; else START.
  - DONE: oBUSY=0, oDONE=1, bus released, oLUT_IDX held at LUT_LEN-1.
    - HPD event → next cycle oDONE=0, oERR=0, oBUSY=1, index 0, go to START. No INIT delay.
- HPD event while busy (any state other than DONE): set pending. The current transaction completes normally through STOP/GAP. Multiple events collapse into one.
- HPD event in INIT: ignored, since playback already starts from 0.
- The divider does not reset on state change. Only reset clears it.

## Timing
- One entry = 4 (START) + 3×36 (bytes + ACK) + 4 (STOP) + 4 (GAP) = 120 qticks = 120·QDIV cycles, when ACKed.
- Full playback = INIT_QT·QDIV + LUT_LEN·120·QDIV cycles, ±QDIV for divider phase.
- All outputs are registered. OE changes occur 1 cycle after the qtick edge.
- HPD-to-restart latency from DONE: 2 sync cycles + 1 edge-detect cycle + 1 cycle.
- Mid-transfer reset: bus is released on the next edge with no STOP issued. This is acceptable; the slave recovers on the next START.

## Test plan
- CLK_HZ=800, I2C_HZ=100 (QDIV=2), LUT_LEN=2, table {16'h4110, 16'h9803}, slave always ACKs.
  - Required: decoded bytes 72 41 10, then 72 98 03.
  - oDONE rises at cycle 16·2 + 240·2 (±2); oERR=0.
- NACK on the data byte of entry 0 every time, MAX_RETRY=3: exactly 4 attempts at index 0, then index 1 proceeds. Final oDONE=1, oERR=1.
- NACK only on the first attempt: 2 transactions at index 0. oERR stays 0.
- iHPD_INT pulse (3 cycles) in DONE: oDONE falls within 4 cycles, the table replays from index 0, oERR is cleared.
- Two iHPD_INT pulses during entry 1's BITS: entry 1 completes with STOP, then exactly one restart from index 0. No extra replay afterward.
- Reset asserted mid-byte: on the next edge oSCL_OE=oSDA_OE=oBUSY=oDONE=0. After release, INIT timing restarts and the first START appears after INIT_QT qticks.
